dk_sound_mixer: RTL and testbench
=================================

Name: dk_sound_mixer

Overview:
- Downstream stage of the walk sound generator.
- Sums the walk output with three other discrete-sound channels (jump, stomp, background) into one signed 16-bit sample for the audio output path.
- Time-multiplexed: one shared multiplier processes one channel per clk after each audio_clk_en.
- Applies per-channel gain, saturates the sum, and reports clipping and overrun.

Parameters:
- CLOCK_RATE, 1000000, system clk rate in Hz. Must satisfy CLOCK_RATE/SAMPLE_RATE >= 6.
- SAMPLE_RATE, 48000, audio_clk_en rate in Hz.
- GAIN0, 64, unsigned 8-bit Q2.6 gain for ch0 (walk). 64 = unity.
- GAIN1, 64, gain for ch1.
- GAIN2, 64, gain for ch2.
- GAIN3, 64, gain for ch3.

Ports:
- clk  in  1  system clock
- I_RST  in  1  asynchronous reset, active-high
- audio_clk_en  in  1  sample strobe, 1-clk pulse
- mute  in  1  forces all gains to 0 for the sample being captured
- in0  in  16  signed, walk channel
- in1  in  16  signed
- in2  in  16  signed
- in3  in  16  signed
- out  out  16  signed mixed sample
- out_valid  out  1  1-clk pulse when out updates
- clip_count  out  16  saturating count of clipped samples
- overrun  out  1  sticky; set when audio_clk_en arrives while busy

Behaviour:
- Reset (I_RST high, async): out=0, out_valid=0, clip_count=0, overrun=0, FSM=IDLE, accumulator=0, channel index=0, snapshot registers=0.
- FSM states: IDLE, ACC, SAT.
- IDLE:
  - On the clk edge where audio_clk_en=1, capture in0..in3 into snapshot registers.
  - Capture effective gains (GAINn, or 0 if mute=1) at the same edge.
  - Clear accumulator, set index=0, go to ACC.
- ACC:
  - Each edge: acc <= acc + ((snap[idx] * gain[idx]) >>> 6), then idx++.
  - Product is 24-bit signed (16-bit signed x 9-bit zero-extended gain).
  - >>> is an arithmetic shift (floor, no rounding).
  - Accumulator is 20-bit signed; it cannot overflow for 4 channels at max gain 255.
  - After the idx=3 edge, go to SAT.
- SAT (one edge):
  - out <= clamp(acc, -32768, 32767); out_valid <= 1.
  - If clamping occurred: clip_count <= clip_count+1, saturating at 65535.
  - Go to IDLE.
- out_valid is high for exactly the one cycle after the SAT edge, otherwise 0.
- out holds its value between updates.
- Latency: strobe at edge T -> ACC edges T+1..T+4 -> SAT edge T+5 -> out/out_valid visible after T+5.
- Input changes after the capture edge do not affect the sample in progress.
- audio_clk_en=1 while in ACC or SAT: the strobe is ignored (no recapture, no restart) and overrun <= 1. overrun clears only on reset.
- audio_clk_en on the same edge SAT returns to IDLE: ignored, and overrun set.
- mute is sampled only at the capture edge. A muted sample gives out=0 and out_valid still pulses.
- Reset asserted mid-computation: everything returns to reset values immediately. No out_valid is produced for the aborted sample.

Test Plan:
- Unity gains; in0..3 = 1000, 2000, 3000, 4000; one strobe -> out=10000 with out_valid exactly 5 clks after the strobe edge; clip_count=0.
- Unity gains; all inputs 30000 -> out=32767, clip_count=1. Then all inputs -30000 -> out=-32768, clip_count=2.
- GAIN0=32, others 0; in0=-3 -> out=-2 (floor of -1.5). in0=3 -> out=1.
- Strobe with mute=1 and inputs 5000 -> out=0, out_valid pulses. Next strobe with mute=0 -> out=20000 (unity gains).
- Two strobes 2 clks apart -> only one out_valid; overrun=1 and stays 1 across later normal samples; inputs changed after capture do not affect out.
- Assert I_RST during ACC -> out=0, out_valid=0, clip_count=0, overrun=0, no pulse. After release, a normal strobe gives the correct sum.

Source files
------------

// File: rtl/dk_sound_mixer.sv
// dk_sound_mixer
//    Four-channel discrete-sound mixer that sits downstream of the walk sound
//    generator. On each audio sample strobe it snapshots the four channel
//    inputs and their effective gains. It then walks one channel per clock
//    through a single shared multiplier into a 20-bit accumulator. Finally it
//    saturates the sum to a signed 16-bit output sample.
//
//    Ports:
//       clk          system clock
//       I_RST        asynchronous reset, active-high
//       audio_clk_en sample strobe, one-clock pulse
//       mute         forces all gains to zero for the sample being captured
//       in0..in3     signed 16-bit channel inputs (in0 = walk)
//       out          signed 16-bit mixed sample, held between updates
//       out_valid    one-clock pulse when out updates
//       clip_count   saturating count of samples that had to be clamped
//       overrun      sticky flag: a strobe arrived while a sample was in flight
module dk_sound_mixer #(
   parameter int          CLOCK_RATE  = 1000000,
   parameter int          SAMPLE_RATE = 48000,
   parameter logic [7:0]  GAIN0       = 8'd64,
   parameter logic [7:0]  GAIN1       = 8'd64,
   parameter logic [7:0]  GAIN2       = 8'd64,
   parameter logic [7:0]  GAIN3       = 8'd64
) (
   input  logic               clk,
   input  logic               I_RST,
   input  logic               audio_clk_en,
   input  logic               mute,
   input  logic signed [15:0] in0,
   input  logic signed [15:0] in1,
   input  logic signed [15:0] in2,
   input  logic signed [15:0] in3,
   output logic signed [15:0] out,
   output logic               out_valid,
   output logic [15:0]        clip_count,
   output logic               overrun
);

   // A sample takes six clocks (capture, four accumulate steps, saturate).
   // With a slower clock-to-sample ratio every strobe would land mid-sample,
   // so such a configuration is rejected at elaboration.
   if (CLOCK_RATE / SAMPLE_RATE < 6) begin : g_rate_too_low
      rate_ratio_below_six_not_supported u_bad_rate ();
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_SAT
   } state_t;

   state_t                state_q, state_d;
   logic signed [15:0]    snap_q [4];
   logic signed [15:0]    snap_d [4];
   logic [7:0]            gain_q [4];
   logic [7:0]            gain_d [4];
   logic signed [19:0]    acc_q, acc_d;
   logic [1:0]            idx_q, idx_d;
   logic signed [15:0]    out_q, out_d;
   logic                  out_valid_q, out_valid_d;
   logic [15:0]           clip_count_q, clip_count_d;
   logic                  overrun_q, overrun_d;

   logic signed [8:0]     cur_gain;
   logic signed [23:0]    product;
   logic signed [23:0]    term;
   logic                  clip_hi;
   logic                  clip_lo;

   // Shared multiplier: the gain is zero-extended so it multiplies as a
   // positive signed value; the arithmetic shift floors toward minus infinity.
   always_comb begin
      cur_gain = $signed({1'b0, gain_q[idx_q]});
      product  = 24'(snap_q[idx_q]) * 24'(cur_gain);
      term     = product >>> 6;
      clip_hi  = (acc_q > 20'sd32767);
      clip_lo  = (acc_q < -20'sd32768);
   end

   // State register plus all datapath and output flops.
   always_ff @(posedge clk or posedge I_RST) begin
      if (I_RST) begin
         state_q      <= ST_IDLE;
         for (int i = 0; i < 4; i++) begin
            snap_q[i] <= '0;
            gain_q[i] <= '0;
         end
         acc_q        <= '0;
         idx_q        <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         clip_count_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         gain_q       <= gain_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         clip_count_q <= clip_count_d;
         overrun_q    <= overrun_d;
      end
   end

   // Next-state and accumulator sequencing. A strobe is only honoured in
   // IDLE, so a sample in flight can never be restarted or recaptured.
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      gain_d  = gain_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (audio_clk_en) begin
               snap_d[0] = in0;
               snap_d[1] = in1;
               snap_d[2] = in2;
               snap_d[3] = in3;
               gain_d[0] = mute ? 8'd0 : GAIN0;
               gain_d[1] = mute ? 8'd0 : GAIN1;
               gain_d[2] = mute ? 8'd0 : GAIN2;
               gain_d[3] = mute ? 8'd0 : GAIN3;
               acc_d     = '0;
               idx_d     = '0;
               state_d   = ST_ACC;
            end
         end
         ST_ACC: begin
            // Each scaled term fits in 18 bits, so truncating to the
            // accumulator width is lossless and four terms cannot overflow.
            acc_d = acc_q + 20'(term);
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = ST_SAT;
            end
         end
         ST_SAT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: saturation, clip counting and the overrun flag.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = 1'b0;
      clip_count_d = clip_count_q;
      overrun_d    = overrun_q | (audio_clk_en && (state_q != ST_IDLE));
      if (state_q == ST_SAT) begin
         out_valid_d = 1'b1;
         if (clip_hi) begin
            out_d = 16'sh7FFF;
         end else if (clip_lo) begin
            out_d = -16'sh8000;
         end else begin
            out_d = acc_q[15:0];
         end
         if ((clip_hi || clip_lo) && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
         end
      end
   end

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign clip_count = clip_count_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_dk_sound_mixer.sv
// tb_dk_sound_mixer
//    Drives two mixer instances with shared inputs: one at unity gains and one
//    with uneven gains (32, 255, 0, 100). Each result is compared against a
//    plain-arithmetic reference: sum of floor(in*gain/64), clamped to 16 bits.
module tb_dk_sound_mixer;

   localparam int GA [4] = '{64, 64, 64, 64};
   localparam int GB [4] = '{32, 255, 0, 100};

   logic               clk = 1'b0;
   logic               I_RST;
   logic               audio_clk_en;
   logic               mute;
   logic signed [15:0] in0, in1, in2, in3;

   logic signed [15:0] out_a, out_b;
   logic               out_valid_a, out_valid_b;
   logic [15:0]        clip_count_a, clip_count_b;
   logic               overrun_a, overrun_b;

   int totalChecks = 0;
   int badChecks   = 0;
   int clipA = 0;
   int clipB = 0;
   int ovrExp = 0;

   always #5 clk = ~clk;

   dk_sound_mixer u_dut_a (
      .clk          (clk),
      .I_RST        (I_RST),
      .audio_clk_en (audio_clk_en),
      .mute         (mute),
      .in0          (in0),
      .in1          (in1),
      .in2          (in2),
      .in3          (in3),
      .out          (out_a),
      .out_valid    (out_valid_a),
      .clip_count   (clip_count_a),
      .overrun      (overrun_a)
   );

   dk_sound_mixer #(
      .GAIN0 (8'd32),
      .GAIN1 (8'd255),
      .GAIN2 (8'd0),
      .GAIN3 (8'd100)
   ) u_dut_b (
      .clk          (clk),
      .I_RST        (I_RST),
      .audio_clk_en (audio_clk_en),
      .mute         (mute),
      .in0          (in0),
      .in1          (in1),
      .in2          (in2),
      .in3          (in3),
      .out          (out_b),
      .out_valid    (out_valid_b),
      .clip_count   (clip_count_b),
      .overrun      (overrun_b)
   );

   // Compare one observed value against its expected value and log a mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Floor division by 64, written without shifts.
   function automatic int floorDiv64(input int p);
      if (p >= 0) return p / 64;
      return -((-p + 63) / 64);
   endfunction

   function automatic int mixRaw(input int v0, input int v1, input int v2, input int v3,
                                 input int g0, input int g1, input int g2, input int g3);
      return floorDiv64(v0 * g0) + floorDiv64(v1 * g1) + floorDiv64(v2 * g2) + floorDiv64(v3 * g3);
   endfunction

   function automatic int clampS16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // One sample: strobe, optional second strobe on negedge extraAt-1 after the
   // capture edge, optional scrambling of inputs after capture, then checks.
   task automatic applyStimulus(input string tag, input int v0, input int v1, input int v2,
                                input int v3, input bit m, input int extraAt, input bit scramble);
      int rawA, rawB, expA, expB;
      int pulsesA, pulsesB, firstAt, gotA, gotB;
      rawA = m ? 0 : mixRaw(v0, v1, v2, v3, GA[0], GA[1], GA[2], GA[3]);
      rawB = m ? 0 : mixRaw(v0, v1, v2, v3, GB[0], GB[1], GB[2], GB[3]);
      expA = clampS16(rawA);
      expB = clampS16(rawB);
      if (expA != rawA && clipA < 65535) clipA++;
      if (expB != rawB && clipB < 65535) clipB++;
      if (extraAt != 0) ovrExp = 1;
      pulsesA = 0;
      pulsesB = 0;
      firstAt = -1;
      gotA    = 0;
      gotB    = 0;
      @(negedge clk);
      in0 = 16'(v0);
      in1 = 16'(v1);
      in2 = 16'(v2);
      in3 = 16'(v3);
      mute = m;
      audio_clk_en = 1'b1;
      for (int n = 0; n <= 10; n++) begin
         @(negedge clk);
         if (out_valid_a) begin
            pulsesA++;
            if (firstAt < 0) begin
               firstAt = n;
               gotA = int'(out_a);
               gotB = int'(out_b);
            end
         end
         if (out_valid_b) pulsesB++;
         audio_clk_en = (extraAt != 0) && (n == extraAt - 1);
         if (n == 0 && scramble) begin
            in0 = 16'($urandom);
            in1 = 16'($urandom);
            in2 = 16'($urandom);
            in3 = 16'($urandom);
            mute = ~m;
         end
      end
      checkOutput({tag, ".pulsesA"}, pulsesA, 1);
      checkOutput({tag, ".pulsesB"}, pulsesB, 1);
      checkOutput({tag, ".latency"}, firstAt, 5);
      checkOutput({tag, ".outA"}, gotA, expA);
      checkOutput({tag, ".outB"}, gotB, expB);
      checkOutput({tag, ".holdA"}, int'(out_a), expA);
      checkOutput({tag, ".clipA"}, int'(clip_count_a), clipA);
      checkOutput({tag, ".clipB"}, int'(clip_count_b), clipB);
      checkOutput({tag, ".overrunA"}, int'(overrun_a), ovrExp);
      checkOutput({tag, ".overrunB"}, int'(overrun_b), ovrExp);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".outA"}, int'(out_a), 0);
      checkOutput({tag, ".validA"}, int'(out_valid_a), 0);
      checkOutput({tag, ".clipA"}, int'(clip_count_a), 0);
      checkOutput({tag, ".overrunA"}, int'(overrun_a), 0);
      checkOutput({tag, ".outB"}, int'(out_b), 0);
      checkOutput({tag, ".clipB"}, int'(clip_count_b), 0);
      checkOutput({tag, ".overrunB"}, int'(overrun_b), 0);
   endtask

   initial begin
      int pulses;
      I_RST = 1'b1;
      audio_clk_en = 1'b0;
      mute = 1'b0;
      in0 = '0;
      in1 = '0;
      in2 = '0;
      in3 = '0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      I_RST = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus("sum", 1000, 2000, 3000, 4000, 1'b0, 0, 1'b0);
      applyStimulus("clipHi", 30000, 30000, 30000, 30000, 1'b0, 0, 1'b0);
      applyStimulus("clipLo", -30000, -30000, -30000, -30000, 1'b0, 0, 1'b0);
      applyStimulus("floorNeg", -3, 0, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus("floorPos", 3, 0, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus("muted", 5000, 5000, 5000, 5000, 1'b1, 0, 1'b0);
      applyStimulus("unmuted", 5000, 5000, 5000, 5000, 1'b0, 0, 1'b0);
      applyStimulus("overrunAcc", 1234, -2345, 3456, -4567, 1'b0, 2, 1'b1);
      applyStimulus("overrunSat", -700, 800, 9000, 12000, 1'b0, 5, 1'b1);

      for (int i = 0; i < 20; i++) begin
         applyStimulus($sformatf("rand%0d", i),
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       ($urandom_range(0, 3) == 0), 0, $urandom_range(0, 1) == 1);
      end

      // Reset in the middle of accumulation aborts the sample entirely.
      @(negedge clk);
      in0 = 16'sd100;
      in1 = 16'sd200;
      in2 = 16'sd300;
      in3 = 16'sd400;
      mute = 1'b0;
      audio_clk_en = 1'b1;
      @(negedge clk);
      audio_clk_en = 1'b0;
      @(negedge clk);
      I_RST = 1'b1;
      #1;
      clipA = 0;
      clipB = 0;
      ovrExp = 0;
      checkResetState("midReset");
      repeat (2) @(negedge clk);
      I_RST = 1'b0;
      pulses = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (out_valid_a || out_valid_b) pulses++;
      end
      checkOutput("abortedPulse", pulses, 0);
      applyStimulus("afterReset", 1000, 2000, 3000, 4000, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
